nway_trace_dispatcher: RTL
==========================

NWAY_TRACE_DISPATCHER -- requirements
Module: nway_trace_dispatcher

Interface
REQ-001 SHALL have parameters: DATA_ADDR_WIDTH, default 16, data address width; DATA_DATA_WIDTH, default 32, instruction width; REQ_TIMEOUT, default 64, wait cycles before cancel.
REQ-002 SHALL use one clock; reset is synchronous and active-high: clk  in  1  clock; rst  in  1  synchronous active-high reset.
REQ-003 enable  in  1  dispatching permitted (driven from repository lock).
REQ-004 trace_req  out  1  request next entry; cancel  out  1  abandon a stalled request.
REQ-005 trace_in  in  trace_repo_data_entry  entry; trace_index_i  in  $clog2(TRACE_ENTRIES)  its index.
REQ-006 entry_valid, cancelled, processing_complete  in  1 each  repository responses.
REQ-007 mem_req  out  1; mem_addr_o  out  DATA_ADDR_WIDTH; mem_we  out  1; mem_gnt  in  1; mem_done  in  1; mem_cache_index  in  $clog2(CACHE_BLOCKS)  block filled.
REQ-008 mark_done  out  1; index_done  out  $clog2(TRACE_ENTRIES); cache_index  out  $clog2(CACHE_BLOCKS); processing_flag  out  1; mem_trace_flag  out  1; mem_addr  out  DATA_ADDR_WIDTH; mark_done_valid  in  1.
REQ-009 busy  out  1  not IDLE/FINISHED; finished  out  1  repository drained.

Function
REQ-010 SHALL implement states IDLE, REQUEST, ISSUE, WAIT_MEM, MARK, FINISHED.
REQ-011 IDLE -> REQUEST when enable=1; trace_req SHALL assert on the REQUEST-entry edge and hold until a response.
REQ-012 REQUEST: entry_valid=1 -> latch trace_in and trace_index_i, drop trace_req, -> ISSUE next cycle.
REQ-013 REQUEST: processing_complete=1 -> drop trace_req, -> FINISHED; finished=1 held until rst.
REQ-014 REQUEST: wait counter increments per cycle; at REQ_TIMEOUT cancel SHALL assert and hold until cancelled=1, then counter clears, trace_req and cancel drop for one cycle, re-request.
REQ-015 entry_valid and cancelled in same cycle: entry_valid wins, cancel dropped.
REQ-016 ISSUE: mem_req=1, mem_addr_o=latched mem_addr, mem_we=1 when instruction[6:0]=7'b0100011 else 0; hold until mem_gnt, then -> WAIT_MEM.
REQ-017 WAIT_MEM: on mem_done latch mem_cache_index, -> MARK.
REQ-018 MARK: mark_done=1 with index_done=latched index, cache_index=latched block, mem_addr=latched address, processing_flag=1, mem_trace_flag=1; hold until mark_done_valid, then drop and -> IDLE (enable=0) or REQUEST.
REQ-019 enable falling mid-transaction SHALL NOT abort; block returns to IDLE after MARK.
REQ-020 All control outputs SHALL be registered; no combinational input-to-output path.
REQ-021 Wait counter saturates at REQ_TIMEOUT; width $clog2(REQ_TIMEOUT)+1.

Reset
REQ-022 rst=1 at any state SHALL force IDLE next edge; all outputs 0, latched entry, index and counter 0.
REQ-023 Outstanding mem_req or mark_done dropped on reset; no completion replayed afterwards.

Configuration
REQ-024 DISPATCH_STATS_EN defined: add outputs stat_dispatched (32) incremented per accepted mark_done_valid, stat_cancelled (32) incremented per cancelled handshake, both cleared by rst.
REQ-025 DISPATCH_STATS_EN undefined: ports and counters absent; all other behaviour identical.

Structure
REQ-026 Package nway_trace_dispatcher_datatypes SHALL hold dispatcher state enum and OPCODE_LOAD/OPCODE_STORE constants; trace_repo_data_entry from nway_trace_repository_datatypes, CACHE_BLOCKS from nway_cache_def.
REQ-027 Single sub-module dispatch_timeout_counter (clear, count, expired) SHALL implement REQ-014/021.

Verification
REQ-028 enable=1, entry_valid with index 3, addr 0x0040, load opcode -> mem_req, mem_we=0, mem_addr_o=0x0040; mem_done block 5 -> mark_done index_done=3, cache_index=5.
REQ-029 Store opcode 0x23 entry -> mem_we=1; mark_done_valid delayed 4 cycles -> mark_done held 4 cycles, then REQUEST.
REQ-030 No response 64 cycles -> cancel asserts cycle 64; cancelled next cycle -> cancel drops, trace_req reasserts after 1 cycle.
REQ-031 processing_complete=1 in REQUEST -> finished=1, busy=0, no further trace_req.
REQ-032 rst pulsed in WAIT_MEM -> next cycle all outputs 0, state IDLE; later mem_done ignored.
REQ-033 DISPATCH_STATS_EN defined, 3 dispatches plus 1 cancel -> stat_dispatched=3, stat_cancelled=1.

Source files
------------

// File: rtl/nway_cache_def.sv
// nway_cache_def: cache geometry shared by cache-side blocks.
package nway_cache_def;
    localparam int CACHE_BLOCKS = 8;
endpackage

// File: rtl/nway_trace_dispatcher_datatypes.sv
// nway_trace_dispatcher_datatypes: dispatcher states and memory opcodes.
package nway_trace_dispatcher_datatypes;
    typedef enum logic [2:0] {IDLE, REQUEST, ISSUE, WAIT_MEM, MARK, FINISHED} dispatch_state_t;
    localparam logic [6:0] OPCODE_LOAD = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE = 7'b0100011;
endpackage

// File: rtl/nway_trace_repository_datatypes.sv
// nway_trace_repository_datatypes: trace repository entry layout and depth.
package nway_trace_repository_datatypes;
    localparam int TRACE_ENTRIES = 16;
    localparam int TRACE_ADDR_WIDTH = 16;
    localparam int TRACE_INSN_WIDTH = 32;
    typedef struct packed {
        logic [TRACE_INSN_WIDTH-1:0] instruction;
        logic [TRACE_ADDR_WIDTH-1:0] mem_addr;
    } trace_repo_data_entry;
endpackage

// File: rtl/dispatch_timeout_counter.sv
// dispatch_timeout_counter: saturating request wait counter with a registered expiry flag.
module dispatch_timeout_counter #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count,
    output logic expired
);
    localparam int W = $clog2(TIMEOUT) + 1;
    localparam logic [W-1:0] LIMIT = W'(TIMEOUT);
    logic [W-1:0] cnt;
    // expired rises on the same edge cnt reaches LIMIT, so it is a plain flop
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
            expired <= 1'b0;
        end else if (count) begin
            if (cnt != LIMIT) cnt <= cnt + 1'b1;
            expired <= cnt >= LIMIT - 1'b1;
        end
    end
endmodule

// File: rtl/nway_trace_dispatcher.sv
// nway_trace_dispatcher: fetches trace entries, issues one memory access each, then marks them done.
// Defining DISPATCH_STATS_EN adds stat_dispatched/stat_cancelled event counters.
module nway_trace_dispatcher
    import nway_trace_dispatcher_datatypes::*;
    import nway_trace_repository_datatypes::*;
    import nway_cache_def::*;
#(
    parameter int DATA_ADDR_WIDTH = 16,
    parameter int DATA_DATA_WIDTH = 32,
    parameter int REQ_TIMEOUT = 64
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              enable,
    output logic                              trace_req,
    output logic                              cancel,
    input  trace_repo_data_entry              trace_in,
    input  logic [$clog2(TRACE_ENTRIES)-1:0]  trace_index_i,
    input  logic                              entry_valid,
    input  logic                              cancelled,
    input  logic                              processing_complete,
    output logic                              mem_req,
    output logic [DATA_ADDR_WIDTH-1:0]        mem_addr_o,
    output logic                              mem_we,
    input  logic                              mem_gnt,
    input  logic                              mem_done,
    input  logic [$clog2(CACHE_BLOCKS)-1:0]   mem_cache_index,
    output logic                              mark_done,
    output logic [$clog2(TRACE_ENTRIES)-1:0]  index_done,
    output logic [$clog2(CACHE_BLOCKS)-1:0]   cache_index,
    output logic                              processing_flag,
    output logic                              mem_trace_flag,
    output logic [DATA_ADDR_WIDTH-1:0]        mem_addr,
    input  logic                              mark_done_valid,
    output logic                              busy,
    output logic                              finished
`ifdef DISPATCH_STATS_EN
    ,
    output logic [31:0]                       stat_dispatched,
    output logic [31:0]                       stat_cancelled
`endif
);
    dispatch_state_t state;
    logic [DATA_ADDR_WIDTH-1:0] addr_q;
    logic [$clog2(TRACE_ENTRIES)-1:0] index_q;
    logic [$clog2(CACHE_BLOCKS)-1:0] block_q;
    logic [DATA_DATA_WIDTH-1:0] insn;
    logic unused_insn;
    logic in_req;
    logic cancel_ack;
    logic respond;
    assign insn = DATA_DATA_WIDTH'(trace_in.instruction);
    assign unused_insn = ^insn[DATA_DATA_WIDTH-1:7];
    assign in_req = state == REQUEST && trace_req;
    // a valid entry or completion in the same cycle takes precedence over the cancel handshake
    assign cancel_ack = in_req && cancel && cancelled && !entry_valid && !processing_complete;
    assign respond = in_req && (entry_valid || processing_complete || cancel_ack);
    dispatch_timeout_counter #(.TIMEOUT(REQ_TIMEOUT)) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (!in_req || respond),
        .count   (in_req),
        .expired (cancel)
    );
    assign mem_addr_o = addr_q;
    assign mem_addr = addr_q;
    assign index_done = index_q;
    assign cache_index = block_q;
    assign processing_flag = mark_done;
    assign mem_trace_flag = mark_done;
    assign busy = state != IDLE && state != FINISHED;
    assign finished = state == FINISHED;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            trace_req <= 1'b0;
            mem_req <= 1'b0;
            mem_we <= 1'b0;
            mark_done <= 1'b0;
            addr_q <= '0;
            index_q <= '0;
            block_q <= '0;
        end else begin
            case (state)
                IDLE: if (enable) begin
                    state <= REQUEST;
                    trace_req <= 1'b1;
                end
                REQUEST: if (!trace_req) trace_req <= 1'b1;
                else if (entry_valid) begin
                    trace_req <= 1'b0;
                    state <= ISSUE;
                    addr_q <= DATA_ADDR_WIDTH'(trace_in.mem_addr);
                    index_q <= trace_index_i;
                    mem_req <= 1'b1;
                    mem_we <= insn[6:0] == OPCODE_STORE;
                end else if (processing_complete) begin
                    trace_req <= 1'b0;
                    state <= FINISHED;
                end else if (cancel_ack) trace_req <= 1'b0;
                ISSUE: if (mem_gnt) begin
                    mem_req <= 1'b0;
                    mem_we <= 1'b0;
                    state <= WAIT_MEM;
                end
                WAIT_MEM: if (mem_done) begin
                    block_q <= mem_cache_index;
                    mark_done <= 1'b1;
                    state <= MARK;
                end
                MARK: if (mark_done_valid) begin
                    mark_done <= 1'b0;
                    trace_req <= enable;
                    state <= enable ? REQUEST : IDLE;
                end
                default: ;
            endcase
        end
    end
`ifdef DISPATCH_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_dispatched <= '0;
            stat_cancelled <= '0;
        end else begin
            if (state == MARK && mark_done_valid) stat_dispatched <= stat_dispatched + 32'd1;
            if (cancel_ack) stat_cancelled <= stat_cancelled + 32'd1;
        end
    end
`endif
endmodule
